// File: rtl/led_share_arbiter.sv
// led_share_arbiter: lends the single board LED to one of two debounced
// switches at a time. Each press posts a one-deep request; a round-robin
// arbiter grants the LED for HOLD_CYCLES. Switch 1 owns a solid LED,
// switch 2 owns a blinking LED.
module led_share_arbiter #(
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned HOLD_CYCLES    = 25000000,
  parameter int unsigned BLINK_HALF     = 3125000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch_1,
  input  logic i_Switch_2,
  output logic o_LED_1,
  output logic o_Grant_1,
  output logic o_Grant_2,
  output logic o_Busy
);

  // Counter widths; a limit of 1 still needs a one-bit register.
  localparam int unsigned DW = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam int unsigned HW = (HOLD_CYCLES    > 1) ? $clog2(HOLD_CYCLES)    : 1;
  localparam int unsigned BW = (BLINK_HALF     > 1) ? $clog2(BLINK_HALF)     : 1;

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_LIMIT - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_1,
    GRANT_2
  } state_e;

  // Bit 0 belongs to switch 1, bit 1 to switch 2 throughout.
  logic [1:0]         sw_raw;
  logic [1:0]         meta_q;
  logic [1:0]         sync_q;
  logic [1:0]         deb_q;
  logic [1:0]         deb_d;
  logic [1:0]         deb_prev_q;
  logic [1:0]         press_q;
  logic [1:0][DW-1:0] db_cnt_q;
  logic [1:0][DW-1:0] db_cnt_d;

  logic [1:0]         pend_q;
  logic [1:0]         start_d;
  logic               last2_q;
  state_e             state_q;
  logic [HW-1:0]      hold_q;
  logic [BW-1:0]      blink_q;
  logic               led_q;
  logic               grant1_q;
  logic               grant2_q;
  logic               busy_q;

  assign sw_raw = {i_Switch_2, i_Switch_1};

  // Two-flop synchroniser per switch.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= sw_raw;
      sync_q <= meta_q;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_LIMIT consecutive
  // differing samples; any agreeing sample restarts the count.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          deb_d[i] = sync_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounced level, its previous value, and the registered press pulse.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      deb_q      <= '0;
      db_cnt_q   <= '0;
      deb_prev_q <= '0;
      press_q    <= '0;
    end else begin
      deb_q      <= deb_d;
      db_cnt_q   <= db_cnt_d;
      deb_prev_q <= deb_q;
      press_q    <= deb_q & ~deb_prev_q;
    end
  end

  // Round-robin pick from IDLE; on a tie the switch not served last wins.
  always_comb begin
    start_d = '0;
    if (state_q == IDLE) begin
      if (pend_q[0] && pend_q[1]) begin
        if (last2_q) begin
          start_d[0] = 1'b1;
        end else begin
          start_d[1] = 1'b1;
        end
      end else if (pend_q[0]) begin
        start_d[0] = 1'b1;
      end else if (pend_q[1]) begin
        start_d[1] = 1'b1;
      end
    end
  end

  // Grant FSM with pending flags, hold/blink timers and registered outputs.
  // Outputs are loaded alongside the state so they line up with it exactly.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      last2_q  <= 1'b1;
      hold_q   <= '0;
      blink_q  <= '0;
      led_q    <= 1'b0;
      grant1_q <= 1'b0;
      grant2_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // Granting clears the flag even if a new press arrives the same cycle.
      pend_q <= (pend_q | press_q) & ~start_d;
      unique case (state_q)
        IDLE: begin
          if (start_d[0]) begin
            state_q  <= GRANT_1;
            last2_q  <= 1'b0;
            hold_q   <= '0;
            blink_q  <= '0;
            led_q    <= 1'b1;
            grant1_q <= 1'b1;
            busy_q   <= 1'b1;
          end else if (start_d[1]) begin
            state_q  <= GRANT_2;
            last2_q  <= 1'b1;
            hold_q   <= '0;
            blink_q  <= '0;
            led_q    <= 1'b1;
            grant2_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        GRANT_1, GRANT_2: begin
          if (hold_q == HOLD_LAST) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            blink_q  <= '0;
            led_q    <= 1'b0;
            grant1_q <= 1'b0;
            grant2_q <= 1'b0;
            busy_q   <= 1'b0;
          end else begin
            hold_q <= hold_q + 1'b1;
            if (state_q == GRANT_2) begin
              if (blink_q == BLINK_LAST) begin
                blink_q <= '0;
                led_q   <= ~led_q;
              end else begin
                blink_q <= blink_q + 1'b1;
              end
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          led_q    <= 1'b0;
          grant1_q <= 1'b0;
          grant2_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_LED_1   = led_q;
  assign o_Grant_1 = grant1_q;
  assign o_Grant_2 = grant2_q;
  assign o_Busy    = busy_q;

endmodule
